xgriscv_lsu: RTL

//  Load/store initiator between the execute stage and a word-organised data memory port.

---
 rtl/xgriscv_lsu_pkg.sv | 29 ++
 rtl/xgriscv_lsu_lane_align.sv | 52 +++++
 rtl/xgriscv_lsu.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/xgriscv_lsu_pkg.sv
// rtl/xgriscv_lsu_pkg.sv - shared size encodings, FSM states and helpers for the LSU
package xgriscv_lsu_pkg;

  // Access size encodings carried on req_size
  localparam logic [1:0] SZ_B = 2'b01;
  localparam logic [1:0] SZ_H = 2'b10;
  localparam logic [1:0] SZ_W = 2'b11;

  // LSU sequencing states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACC0  = 3'd1,
    ST_DATA0 = 3'd2,
    ST_ACC1  = 3'd3,
    ST_DATA1 = 3'd4,
    ST_RESP  = 3'd5
  } lsu_state_t;

  // Number of bytes moved by a size code; 0 flags an illegal size
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 3'd1;
      SZ_H:    return 3'd2;
      SZ_W:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/xgriscv_lsu_lane_align.sv
// rtl/xgriscv_lsu_lane_align.sv - byte-lane masks, store data alignment and load merge/extend
module xgriscv_lsu_lane_align
  import xgriscv_lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_lu,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo,
  input  logic [31:0] i_hi,
  output logic        o_split,
  output logic [3:0]  o_be_a,
  output logic [3:0]  o_be_b,
  output logic [31:0] o_wdata_a,
  output logic [31:0] o_wdata_b,
  output logic [31:0] o_rdata
);

  logic [3:0]  w_base;
  logic [6:0]  w_mask;
  logic [63:0] w_wide;
  logic [63:0] w_merged;

  // Lane mask over the two words touched, aligned store data, and extended load result
  always_comb begin
    case (i_size)
      SZ_B:    w_base = 4'b0001;
      SZ_H:    w_base = 4'b0011;
      SZ_W:    w_base = 4'b1111;
      default: w_base = 4'b0000;
    endcase
    w_mask    = {3'b000, w_base} << i_off;
    o_be_a    = w_mask[3:0];
    o_be_b    = {1'b0, w_mask[6:4]};
    o_split   = |w_mask[6:4];

    // Low half feeds access A, high half holds the bytes spilling into access B
    w_wide    = {32'b0, i_wdata} << {i_off, 3'b000};
    o_wdata_a = w_wide[31:0];
    o_wdata_b = w_wide[63:32];

    // Requested bytes end up right-justified; the stale hi word never reaches them when unsplit
    w_merged  = {i_hi, i_lo} >> {i_off, 3'b000};
    case (i_size)
      SZ_B:    o_rdata = i_lu ? {24'b0, w_merged[7:0]}  : {{24{w_merged[7]}},  w_merged[7:0]};
      SZ_H:    o_rdata = i_lu ? {16'b0, w_merged[15:0]} : {{16{w_merged[15]}}, w_merged[15:0]};
      SZ_W:    o_rdata = w_merged[31:0];
      default: o_rdata = 32'b0;
    endcase
  end

endmodule

// File: rtl/xgriscv_lsu.sv
// rtl/xgriscv_lsu.sv - load/store initiator driving byte-enabled word accesses
module xgriscv_lsu
  import xgriscv_lsu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_lu,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic              resp_split,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic [XLEN-1:0]   mem_rdata
);

  lsu_state_t        r_state;
  lsu_state_t        w_next;
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_lu;
  logic [ADDR_W-1:0] r_addr;
  logic [XLEN-1:0]   r_wdata;
  logic              r_err;
  logic [XLEN-1:0]   r_lo;
  logic [XLEN-1:0]   r_hi;

  logic              w_accept;
  logic              w_split;
  logic [3:0]        w_be_a;
  logic [3:0]        w_be_b;
  logic [XLEN-1:0]   w_wdata_a;
  logic [XLEN-1:0]   w_wdata_b;
  logic [XLEN-1:0]   w_rdata;
  logic [ADDR_W-1:0] w_addr_a;
  logic [ADDR_W-1:0] w_addr_b;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_addr_a = {r_addr[ADDR_W-1:2], 2'b00};
  assign w_addr_b = w_addr_a + ADDR_W'(4);

  xgriscv_lsu_lane_align u_align (
    .i_off     (r_addr[1:0]),
    .i_size    (r_size),
    .i_lu      (r_lu),
    .i_wdata   (r_wdata),
    .i_lo      (r_lo),
    .i_hi      (r_hi),
    .o_split   (w_split),
    .o_be_a    (w_be_a),
    .o_be_b    (w_be_b),
    .o_wdata_a (w_wdata_a),
    .o_wdata_b (w_wdata_b),
    .o_rdata   (w_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: stores skip the data phases, unsplit requests skip the second access
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = (size_bytes(req_size) == 3'd0) ? ST_RESP : ST_ACC0;
      ST_ACC0:  w_next = r_we ? (w_split ? ST_ACC1 : ST_RESP) : ST_DATA0;
      ST_DATA0: w_next = w_split ? ST_ACC1 : ST_RESP;
      ST_ACC1:  w_next = r_we ? ST_RESP : ST_DATA1;
      ST_DATA1: w_next = ST_RESP;
      ST_RESP:  if (resp_ready) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Request register, loaded once per accepted request
  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_size  <= 2'b00;
      r_lu    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_size  <= req_size;
      r_lu    <= req_lu;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
      r_err   <= (size_bytes(req_size) == 3'd0);
    end
  end

  // Capture read data the cycle after each load access
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lo <= '0;
      r_hi <= '0;
    end else begin
      if (r_state == ST_DATA0) r_lo <= mem_rdata;
      if (r_state == ST_DATA1) r_hi <= mem_rdata;
    end
  end

  // Memory and response outputs decoded from state; everything idles at zero
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    resp_split = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_be     = 4'b0000;
    mem_wdata  = '0;
    case (r_state)
      ST_IDLE: req_ready = 1'b1;
      ST_ACC0: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_addr_a;
        mem_be    = w_be_a;
        mem_wdata = r_we ? w_wdata_a : '0;
      end
      ST_ACC1: begin
        mem_en    = 1'b1;
        mem_we    = r_we;
        mem_addr  = w_addr_b;
        mem_be    = w_be_b;
        mem_wdata = r_we ? w_wdata_b : '0;
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_split = w_split && !r_err;
        resp_rdata = (r_we || r_err) ? '0 : w_rdata;
      end
      default: ;
    endcase
  end

endmodule
